rst_sequencer: RTL

//  Parametrised power-on / PLL reset sequencer for the FPGA top level. Pulses the PLL areset,

---
 rtl/rst_sequencer_if.sv | 23 ++
 rtl/rst_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rst_sequencer_if.sv
// PLL lock / software-request inputs and staged reset outputs of rst_sequencer.
// The master side drives the lock and the request; the sequencer (slave) drives the resets.
interface rst_sequencer_if #(
    parameter int unsigned N_CH = 3
);
    logic            pll_locked;
    logic            sw_rst_req;
    logic            pll_areset;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic            lock_err;
    logic [3:0]      retry_cnt;

    modport master (
        output pll_locked, sw_rst_req,
        input  pll_areset, rst_out, ready, lock_err, retry_cnt
    );

    modport slave (
        input  pll_locked, sw_rst_req,
        output pll_areset, rst_out, ready, lock_err, retry_cnt
    );
endinterface

// File: rtl/rst_sequencer.sv
// Power-on / PLL reset sequencer: pulses the PLL reset, qualifies lock with timeout and retry,
// then releases the downstream reset domains one by one. Runs on the free-running oscillator.
module rst_sequencer #(
    parameter int unsigned N_CH           = 3,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4096,
    parameter int unsigned LOCK_STABLE    = 256,
    parameter int unsigned STAGGER        = 16,
    parameter int unsigned MAX_RETRY      = 4,
    parameter bit          SW_RST_PLL     = 1'b0
) (
    input logic            CLK12M,
    input logic            reset_n,
    rst_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRelease,
        StRun
    } state_e;

    localparam logic [15:0] CntPllRst  = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] CntTimeout = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] CntStable  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] CntLast    = 16'((N_CH - 1) * STAGGER);
    localparam logic [4:0]  MaxRetry   = 5'(MAX_RETRY);

    logic [1:0]      rst_sync_q;
    logic [1:0]      lock_sync_q;
    logic            rst_s;
    logic            lock_s;
    state_e          state_q;
    logic [15:0]     cnt_q;
    logic            pll_areset_q;
    logic [N_CH-1:0] rst_out_q;
    logic            ready_q;
    logic            lock_err_q;
    logic [3:0]      retry_q;

    assign rst_s  = rst_sync_q[1];
    assign lock_s = lock_sync_q[1];

    // Reset asserts asynchronously but is released only through the synchroniser.
    always_ff @(posedge CLK12M or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            rst_sync_q  <= {rst_sync_q[0], 1'b1};
            lock_sync_q <= {lock_sync_q[0], bus.pll_locked};
        end
    end

    always_ff @(posedge CLK12M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            pll_areset_q <= 1'b1;
            rst_out_q    <= '1;
            ready_q      <= 1'b0;
            lock_err_q   <= 1'b0;
            retry_q      <= '0;
        end else if (!rst_s) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
            case (state_q)
                StPllRst: begin
                    if (cnt_q == CntPllRst) begin
                        state_q      <= StWaitLock;
                        cnt_q        <= '0;
                        pll_areset_q <= 1'b0;
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntTimeout) begin
                        state_q      <= StPllRst;
                        cnt_q        <= '0;
                        pll_areset_q <= 1'b1;
                        if (retry_q != 4'hf) begin
                            retry_q <= retry_q + 4'd1;
                        end
                        if (5'(retry_q) + 5'd1 >= MaxRetry) begin
                            lock_err_q <= 1'b1;
                        end
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntStable) begin
                        state_q <= StRelease;
                        cnt_q   <= '0;
                        retry_q <= '0;
                    end
                end
                StRelease, StRun: begin
                    // Lock loss wins over a simultaneous software request.
                    if (!lock_s) begin
                        state_q      <= StPllRst;
                        cnt_q        <= '0;
                        pll_areset_q <= 1'b1;
                        rst_out_q    <= '1;
                        ready_q      <= 1'b0;
                    end else if (bus.sw_rst_req) begin
                        cnt_q     <= '0;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                        if (SW_RST_PLL) begin
                            state_q      <= StPllRst;
                            pll_areset_q <= 1'b1;
                        end else begin
                            state_q <= StRelease;
                        end
                    end else if (state_q == StRelease) begin
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            if (cnt_q == 16'(i * STAGGER)) begin
                                rst_out_q[i] <= 1'b0;
                            end
                        end
                        if (cnt_q == CntLast) begin
                            state_q <= StRun;
                            cnt_q   <= '0;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StPllRst;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.pll_areset = pll_areset_q;
    assign bus.rst_out    = rst_out_q;
    assign bus.ready      = ready_q;
    assign bus.lock_err   = lock_err_q;
    assign bus.retry_cnt  = retry_q;

endmodule
